// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32IM integer-datapath constants for decode, regfile
//               and writeback.
// Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending bits for long-latency producers, plus
//               the decode-side busy flags for both source operands.
// Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  // x0 never has a producer, so the vector starts at index 1.
  logic [NREGS-1:1] pending_q;
  logic [NREGS-1:1] pending_d;

  for (genvar i = 1; i < NREGS; i++) begin : g_pending_bit
    logic set_hit;
    logic clr_hit;

    assign set_hit = busy_set && (busy_rd == ADDR_W'(i));
    assign clr_hit = clr_en && (clr_rd == ADDR_W'(i));

    // A new producer wins over the retirement of an older one.
    assign pending_d[i] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pending_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  logic rs1_pending;
  logic rs2_pending;

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == ADDR_W'(i)) rs1_pending = pending_q[i];
      if (rs2 == ADDR_W'(i)) rs2_pending = pending_q[i];
    end
  end

  // A retiring write in this cycle is bypassed to the reader, so no stall.
  assign rs1_busy = rs1_pending && !(clr_en && (clr_rd == rs1));
  assign rs2_busy = rs2_pending && !(clr_en && (clr_rd == rs2));

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile
// Description : RV32IM integer register file: 2 bypassed read ports, 1 write
//               port, 1 debug read port, with a pending-producer scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module id_regfile
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en_W,
  input  logic [ADDR_W-1:0] rd_W,
  input  logic [XLEN-1:0]   reg_write_data_W,
  input  logic [ADDR_W-1:0] rs1_D,
  input  logic [ADDR_W-1:0] rs2_D,
  output logic [XLEN-1:0]   rd1_D,
  output logic [XLEN-1:0]   rd2_D,
  input  logic              busy_set_D,
  input  logic [ADDR_W-1:0] busy_rd_D,
  output logic              rs1_busy_D,
  output logic              rs2_busy_D,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  // x0 has no storage; every lookup loop below starts at 1 and defaults to 0.
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_write_en_W && (rd_W == ADDR_W'(i))) begin
        regs_d[i] = reg_write_data_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic [XLEN-1:0] arr_rd1;
  logic [XLEN-1:0] arr_rd2;
  logic [XLEN-1:0] arr_dbg;

  always_comb begin
    arr_rd1 = '0;
    arr_rd2 = '0;
    arr_dbg = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1_D    == ADDR_W'(i)) arr_rd1 = regs_q[i];
      if (rs2_D    == ADDR_W'(i)) arr_rd2 = regs_q[i];
      if (dbg_addr == ADDR_W'(i)) arr_dbg = regs_q[i];
    end
  end

  logic bypass1;
  logic bypass2;

  assign bypass1 = reg_write_en_W && (rd_W == rs1_D) && (rs1_D != ZERO_REG);
  assign bypass2 = reg_write_en_W && (rd_W == rs2_D) && (rs2_D != ZERO_REG);

  assign rd1_D    = bypass1 ? reg_write_data_W : arr_rd1;
  assign rd2_D    = bypass2 ? reg_write_data_W : arr_rd2;
  assign dbg_data = arr_dbg;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .busy_set (busy_set_D),
    .busy_rd  (busy_rd_D),
    .clr_en   (reg_write_en_W),
    .clr_rd   (rd_W),
    .rs1      (rs1_D),
    .rs2      (rs2_D),
    .rs1_busy (rs1_busy_D),
    .rs2_busy (rs2_busy_D)
  );

endmodule : id_regfile
`default_nettype wire

// File: tb/tb_id_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_regfile
// Description : Directed self-checking bench for id_regfile.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en_W;
  logic [4:0]  rd_W;
  logic [31:0] reg_write_data_W;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic [31:0] rd1_D;
  logic [31:0] rd2_D;
  logic        busy_set_D;
  logic [4:0]  busy_rd_D;
  logic        rs1_busy_D;
  logic        rs2_busy_D;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  id_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .reg_write_en_W   (reg_write_en_W),
    .rd_W             (rd_W),
    .reg_write_data_W (reg_write_data_W),
    .rs1_D            (rs1_D),
    .rs2_D            (rs2_D),
    .rd1_D            (rd1_D),
    .rd2_D            (rd2_D),
    .busy_set_D       (busy_set_D),
    .busy_rd_D        (busy_rd_D),
    .rs1_busy_D       (rs1_busy_D),
    .rs2_busy_D       (rs2_busy_D),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge, half a cycle away from the sampling edge.
  task automatic idle();
    @(negedge clk);
    rst = 1'b0; reg_write_en_W = 1'b0; rd_W = '0; reg_write_data_W = '0;
    busy_set_D = 1'b0; busy_rd_D = '0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    idle();
    reg_write_en_W = 1'b1; rd_W = rd; reg_write_data_W = data;
  endtask

  initial begin
    rst = 1'b1; reg_write_en_W = 1'b0; rd_W = '0; reg_write_data_W = '0;
    rs1_D = '0; rs2_D = '0; busy_set_D = 1'b0; busy_rd_D = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);

    // 1. Random writes and a pending producer, then a single reset cycle.
    for (int i = 1; i <= 10; i++) begin
      wb(5'(i), $urandom());
    end
    idle(); busy_set_D = 1'b1; busy_rd_D = 5'd12;
    idle(); rst = 1'b1; reg_write_en_W = 1'b1; rd_W = 5'd3; reg_write_data_W = 32'hFFFF_0000;
    busy_set_D = 1'b1; busy_rd_D = 5'd2;
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_D = 5'(i); rs2_D = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      check($sformatf("rst_rd1_x%0d", i), rd1_D, 32'h0);
      check($sformatf("rst_rd2_x%0d", 31 - i), rd2_D, 32'h0);
      check($sformatf("rst_dbg_x%0d", i), dbg_data, 32'h0);
      check($sformatf("rst_busy1_x%0d", i), {31'b0, rs1_busy_D}, 32'h0);
      check($sformatf("rst_busy2_x%0d", 31 - i), {31'b0, rs2_busy_D}, 32'h0);
    end

    // 2. Plain write then read; writes to x0 are dropped, no x0 bypass.
    wb(5'd5, 32'hDEAD_BEEF);
    idle(); rs1_D = 5'd5; dbg_addr = 5'd5; #1;
    check("wr_x5_rd1", rd1_D, 32'hDEAD_BEEF);
    check("wr_x5_dbg", dbg_data, 32'hDEAD_BEEF);
    wb(5'd0, 32'h0000_1234); rs1_D = 5'd0; rs2_D = 5'd0; #1;
    check("x0_bypass_rd1", rd1_D, 32'h0);
    check("x0_bypass_rd2", rd2_D, 32'h0);
    idle(); dbg_addr = 5'd0; #1;
    check("x0_after_rd1", rd1_D, 32'h0);
    check("x0_after_dbg", dbg_data, 32'h0);
    wb(5'd31, 32'h8000_0001);
    idle(); rs2_D = 5'd31; dbg_addr = 5'd31; #1;
    check("x31_rd2", rd2_D, 32'h8000_0001);
    check("x31_dbg", dbg_data, 32'h8000_0001);

    // 3. Write-first bypass on both ports; debug port shows stored value.
    wb(5'd7, 32'h1111_1111);
    wb(5'd7, 32'hCAFE_F00D); rs1_D = 5'd7; rs2_D = 5'd7; dbg_addr = 5'd7; #1;
    check("byp_rd1", rd1_D, 32'hCAFE_F00D);
    check("byp_rd2", rd2_D, 32'hCAFE_F00D);
    check("byp_dbg_old", dbg_data, 32'h1111_1111);
    idle(); #1;
    check("byp_dbg_new", dbg_data, 32'hCAFE_F00D);
    check("byp_rd1_after", rd1_D, 32'hCAFE_F00D);

    // 4. Scoreboard set, visible next cycle, cleared by the retiring write.
    idle(); busy_set_D = 1'b1; busy_rd_D = 5'd9; rs2_D = 5'd9; #1;
    check("sb_set_same_cyc", {31'b0, rs2_busy_D}, 32'h0);
    idle(); #1;
    check("sb_busy_x9", {31'b0, rs2_busy_D}, 32'h1);
    wb(5'd9, 32'h0000_0055); #1;
    check("sb_retire_busy", {31'b0, rs2_busy_D}, 32'h0);
    check("sb_retire_rd2", rd2_D, 32'h0000_0055);
    idle(); #1;
    check("sb_cleared_x9", {31'b0, rs2_busy_D}, 32'h0);

    // 5. Set and clear of the same register in one cycle: set wins.
    wb(5'd3, 32'h0000_00AA); busy_set_D = 1'b1; busy_rd_D = 5'd3;
    idle(); rs1_D = 5'd3; #1;
    check("sc_busy_x3", {31'b0, rs1_busy_D}, 32'h1);
    check("sc_rd1_x3", rd1_D, 32'h0000_00AA);
    wb(5'd3, 32'h0000_00BB); #1;
    check("sc_retire_busy", {31'b0, rs1_busy_D}, 32'h0);
    idle(); #1;
    check("sc_cleared_x3", {31'b0, rs1_busy_D}, 32'h0);
    check("sc_rd1_bb", rd1_D, 32'h0000_00BB);
    idle(); busy_set_D = 1'b1; busy_rd_D = 5'd0; rs1_D = 5'd0;
    idle(); #1;
    check("sb_x0_ignored", {31'b0, rs1_busy_D}, 32'h0);

    // 6. Reset with pending producers and an in-flight write.
    wb(5'd4, 32'h0000_0044);
    idle(); busy_set_D = 1'b1; busy_rd_D = 5'd4;
    idle(); busy_set_D = 1'b1; busy_rd_D = 5'd9;
    idle(); rs1_D = 5'd4; rs2_D = 5'd9; #1;
    check("mid_busy_x4", {31'b0, rs1_busy_D}, 32'h1);
    check("mid_busy_x9", {31'b0, rs2_busy_D}, 32'h1);
    idle(); rst = 1'b1; reg_write_en_W = 1'b1; rd_W = 5'd4; reg_write_data_W = 32'h0000_0077;
    busy_set_D = 1'b1; busy_rd_D = 5'd12;
    idle(); dbg_addr = 5'd4; #1;
    check("mrst_busy_x4", {31'b0, rs1_busy_D}, 32'h0);
    check("mrst_busy_x9", {31'b0, rs2_busy_D}, 32'h0);
    check("mrst_rd1_x4", rd1_D, 32'h0);
    check("mrst_dbg_x4", dbg_data, 32'h0);
    rs1_D = 5'd12; rs2_D = 5'd5; #1;
    check("mrst_busy_x12", {31'b0, rs1_busy_D}, 32'h0);
    check("mrst_rd2_x5", rd2_D, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_id_regfile
`default_nettype wire
